gray_frame_ctrl: RTL
====================

// Module: gray_frame_ctrl
// PURPOSE
//  Sequences the RGB-to-grayscale datapath over a frame buffer for the image coprocessor.
//  The CPU programs source base, destination base, pixel count and mode, then pulses start.
//  The block streams 12-bit {R,G,B} pixels from the frame BRAM read port, converts each one,
//  and writes it to the BRAM write port. Throughput is 1 pixel/clk. It pauses under CPU hold.
// PARAMETERS
//  ADDR_W   17   frame-buffer word-address width; all address arithmetic is mod 2**ADDR_W
//  CNT_W    17   width of num_pix / internal pixel counter
// PORTS
//  clk       in   1       system clock; all logic on rising edge
//  rst_n     in   1       asynchronous active-low reset
//  start     in   1       1-cycle go pulse; ignored unless state==IDLE
//  mode      in   1       0: grayscale convert; 1: straight copy (wr_data = rd_data)
//  src_base  in   ADDR_W  first source address, latched on accepted start
//  dst_base  in   ADDR_W  first destination address, latched on accepted start
//  num_pix   in   CNT_W   pixels to process, latched on accepted start; 0 is legal
//  hold      in   1       1: issue no new read this cycle (CPU owns the buffer)
//  rd_en     out  1       BRAM read strobe
//  rd_addr   out  ADDR_W  BRAM read address
//  rd_data   in   12      BRAM read data, valid exactly 1 clk after rd_en
//  wr_en     out  1       BRAM write strobe
//  wr_addr   out  ADDR_W  BRAM write address
//  wr_data   out  12      BRAM write data
//  busy      out  1       high from the cycle after an accepted start through the done cycle
//  done      out  1       1-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; rd_en, wr_en, busy, done = 0; rd_addr, wr_addr, wr_data = 0; counters = 0.
//   Reset mid-frame aborts immediately. The aborted in-flight write is not issued.
//  States: IDLE -> RUN (start, num_pix!=0) | DONE (start, num_pix==0).
//   RUN -> DRAIN when the final read issues.
//   DRAIN -> DONE when the final write issues.
//   DONE -> IDLE after 1 clk.
//  RUN: each cycle with hold==0 and issued<num_pix, it drives rd_en=1 and rd_addr=src_base+issued,
//   then increments issued. With hold==1, rd_en=0 and nothing else changes.
//  Pipeline: a read issued in cycle t has rd_data sampled in cycle t+1. A registered write appears
//   in cycle t+2: wr_en=1, wr_addr=dst_base+k (k = that pixel's index), wr_data=f(rd_data).
//   Read-to-write latency is fixed at 2 clk. hold never stalls reads or writes already in flight.
//  f (mode 0): g = (5*R + 9*G + 2*B) computed 8 bits wide, max 240, no overflow.
//   g4 = g[7:4]; wr_data = {g4,g4,g4}.
//  f (mode 1): wr_data = rd_data. mode is latched at start and is stable for the whole frame.
//  Address arithmetic wraps mod 2**ADDR_W. Overlapping src/dst regions are the caller's concern.
//   If dst==src, the frame converts in place correctly.
//  done=1 and busy=1 in the DONE cycle, which is the cycle after the last wr_en. busy=0 in IDLE.
//   num_pix==0: no rd_en/wr_en; done pulses in the cycle after start.
//  A start arriving while not IDLE is dropped: no re-latch, no effect on the current frame.
//  A start arriving in the same cycle done is high is also dropped. The next start is accepted in IDLE.
//  rd_en and wr_en each pulse exactly num_pix times per frame.
// TESTING
//  T1 reset then start; src=0x100, dst=0x200, num_pix=4, mode=0.
//   mem[0x100..0x103]=FFF,F00,0F0,000 -> writes FFF,444,888,000 to 0x200..0x203 on 4 consecutive clks.
//   done arrives 1 clk after the last write.
//  T2 num_pix=0 -> no rd_en/wr_en; busy high 1 clk; done pulses in the cycle after start.
//  T3 num_pix=8, hold=1 for 3 clks after the 2nd read -> exactly 8 reads and 8 writes, order preserved.
//   Each write is exactly 2 clk after its read; the frame takes 3 clks longer.
//  T4 src=0x1FFFE, num_pix=4, mode=1 -> rd_addr 1FFFE,1FFFF,00000,00001; wr_data equals source data.
//  T5 second start pulse mid-frame with different bases -> ignored; original frame completes unchanged.
//  T6 assert rst_n=0 after the 3rd write of 8 -> all outputs 0 at once; a new start runs a full clean frame.

Source files
------------

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer for the RGB-to-grayscale coprocessor. It streams pixels from the BRAM read
// port through a fixed two-stage pipeline to the BRAM write port, at one pixel per clock.
module gray_frame_ctrl #(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned CNT_W  = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [CNT_W-1:0]  num_pix,
   input  logic              hold,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [11:0]       rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, dst_q;
   logic [CNT_W-1:0]    num_q, issued_q, idx1_q;
   logic                mode_q, v1_q;
   logic                wr_en_q, busy_q, done_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [11:0]         wr_data_q;

   logic                issue_c, last_rd_c;
   logic [7:0]          gsum_c;
   logic [3:0]          g4_c;

   // Read issue is gated by hold in the same cycle, so the strobe is decoded from the state.
   always_comb begin
      issue_c   = (state_q == S_RUN) && !hold && (issued_q < num_q);
      last_rd_c = issue_c && (CNT_W'(issued_q + CNT_W'(1)) == num_q);
   end

   assign rd_en   = issue_c;
   assign rd_addr = ADDR_W'(src_q + ADDR_W'(issued_q));

   // Luma weights 5/9/2 out of 16; the sum never exceeds 240 so 8 bits suffice.
   always_comb begin
      gsum_c = 8'(8'({4'd0, rd_data[11:8]}) * 8'd5)
             + 8'(8'({4'd0, rd_data[7:4]})  * 8'd9)
             + 8'(8'({4'd0, rd_data[3:0]})  * 8'd2);
      g4_c   = gsum_c[7:4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (num_pix == '0) ? S_DONE : S_RUN;
         S_RUN:   if (last_rd_c) state_d = S_DRAIN;
         // The final write is on the port once the read stage has emptied.
         S_DRAIN: if (!v1_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q     <= '0;
         dst_q     <= '0;
         num_q     <= '0;
         mode_q    <= 1'b0;
         issued_q  <= '0;
         idx1_q    <= '0;
         v1_q      <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if (state_q == S_IDLE && start) begin
            src_q    <= src_base;
            dst_q    <= dst_base;
            num_q    <= num_pix;
            mode_q   <= mode;
            issued_q <= '0;
         end else if (issue_c) begin
            issued_q <= CNT_W'(issued_q + CNT_W'(1));
         end
         v1_q    <= issue_c;
         idx1_q  <= issued_q;
         wr_en_q <= v1_q;
         if (v1_q) begin
            wr_addr_q <= ADDR_W'(dst_q + ADDR_W'(idx1_q));
            wr_data_q <= mode_q ? rd_data : {g4_c, g4_c, g4_c};
         end
         busy_q <= (state_d != S_IDLE);
         done_q <= (state_d == S_DONE);
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
